// File: rtl/hangman_host_display_gen.sv
// ============================================================================
// Module      : hangman_host_display_gen
// Description : Host-side hangman LCD formatter. It tracks the game phase, the
//               revealed letters, the miss count and the wrong-guess history,
//               and drives two centred 16-character ASCII rows.
//               Optional macro DUP_GUESS_FILTER_EN discards repeated misses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hangman_host_display_gen #(
    parameter int WORD_LEN     = 5,
    parameter int MAX_MISTAKES = 6,
    parameter int GUESS_DEPTH  = 6
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    new_game,
    input  logic [8*WORD_LEN-1:0]   word,
    input  logic                    guess_valid,
    input  logic [7:0]              letter,
    input  logic [WORD_LEN-1:0]     indexCorrect,
    input  logic                    mistake,
    output logic [127:0]            top,
    output logic [127:0]            bottom,
    output logic [3:0]              num_mistake,
    output logic                    game_over,
    output logic                    win
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WIN  = 2'd2,
        S_LOSE = 2'd3
    } state_t;

    localparam logic [3:0]   c_MAX_MISS = 4'(MAX_MISTAKES);
    localparam logic [7:0]   c_BLANK    = 8'h5F;
    localparam logic [7:0]   c_SPACE    = 8'h20;
    localparam logic [127:0] c_WIN_TXT  = {24'h57696E, 104'h0};
    localparam logic [127:0] c_LOSE_TXT = {32'h4C6F7365, 96'h0};

    state_t                     r_state;
    logic [8*WORD_LEN-1:0]      r_word;
    logic [WORD_LEN-1:0]        r_rev;
    logic [8*GUESS_DEPTH-1:0]   r_hist;
    logic [3:0]                 r_miss;
    logic [127:0]               r_top;
    logic [127:0]               r_bottom;
    logic                       r_game_over;
    logic                       r_win;

    state_t                     w_state_n;
    logic [8*WORD_LEN-1:0]      w_word_n;
    logic [WORD_LEN-1:0]        w_rev_n;
    logic [8*GUESS_DEPTH-1:0]   w_hist_n;
    logic [3:0]                 w_miss_n;
    logic                       w_dup;
    logic [127:0]               w_mask_txt;
    logic [127:0]               w_word_txt;
    logic [127:0]               w_hist_txt;
    logic [127:0]               w_top_n;
    logic [127:0]               w_bottom_n;

    // Content is left-aligned in a 16-byte buffer; this places it centred.
    function automatic logic [127:0] f_center(input logic [127:0] content, input int len);
        logic [127:0] row;
        int           pl;
        pl  = (16 - len) / 2;
        row = '0;
        for (int j = 0; j < 16; j++) begin
            if (j >= pl && j < pl + len)
                row[8*(15-j) +: 8] = content[8*(15-(j-pl)) +: 8];
            else
                row[8*(15-j) +: 8] = c_SPACE;
        end
        return row;
    endfunction

`ifdef DUP_GUESS_FILTER_EN
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < GUESS_DEPTH; i++) begin
            if (r_hist[8*i +: 8] != c_BLANK && r_hist[8*i +: 8] == letter)
                w_dup = 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // A hit whose positions are already revealed ORs in nothing, so the
    // duplicate-hit case needs no extra filtering.
    always_comb begin
        w_state_n = r_state;
        w_word_n  = r_word;
        w_rev_n   = r_rev;
        w_hist_n  = r_hist;
        w_miss_n  = r_miss;
        if (new_game) begin
            w_state_n = S_PLAY;
            w_word_n  = word;
            w_rev_n   = '0;
            w_miss_n  = 4'd0;
            w_hist_n  = {GUESS_DEPTH{c_BLANK}};
        end else if (r_state == S_PLAY && guess_valid) begin
            if (mistake) begin
                if (!w_dup) begin
                    w_miss_n = (r_miss >= c_MAX_MISS) ? c_MAX_MISS : r_miss + 4'd1;
                    w_hist_n[8*GUESS_DEPTH-1 -: 8] = letter;
                    for (int i = 1; i < GUESS_DEPTH; i++)
                        w_hist_n[8*(GUESS_DEPTH-1-i) +: 8] = r_hist[8*(GUESS_DEPTH-i) +: 8];
                    if (w_miss_n == c_MAX_MISS)
                        w_state_n = S_LOSE;
                end
            end else begin
                w_rev_n = r_rev | indexCorrect;
                if (&w_rev_n)
                    w_state_n = S_WIN;
            end
        end
    end

    always_comb begin
        w_mask_txt = '0;
        w_word_txt = '0;
        w_hist_txt = '0;
        for (int k = 0; k < WORD_LEN; k++) begin
            w_word_txt[8*(15-k) +: 8] = w_word_n[8*(WORD_LEN-1-k) +: 8];
            w_mask_txt[8*(15-k) +: 8] = w_rev_n[WORD_LEN-1-k] ?
                                        w_word_n[8*(WORD_LEN-1-k) +: 8] : c_BLANK;
        end
        for (int k = 0; k < GUESS_DEPTH; k++)
            w_hist_txt[8*(15-k) +: 8] = w_hist_n[8*(GUESS_DEPTH-1-k) +: 8];

        w_top_n    = '0;
        w_bottom_n = '0;
        case (w_state_n)
            S_PLAY: begin
                w_top_n    = f_center(w_mask_txt, WORD_LEN);
                w_bottom_n = f_center(w_hist_txt, GUESS_DEPTH);
            end
            S_WIN: begin
                w_top_n    = f_center(c_WIN_TXT, 3);
                w_bottom_n = f_center(w_word_txt, WORD_LEN);
            end
            S_LOSE: begin
                w_top_n    = f_center(c_LOSE_TXT, 4);
                w_bottom_n = f_center(w_word_txt, WORD_LEN);
            end
            default: begin
                w_top_n    = '0;
                w_bottom_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_rev       <= '0;
            r_hist      <= '0;
            r_miss      <= 4'd0;
            r_top       <= '0;
            r_bottom    <= '0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_word      <= w_word_n;
            r_rev       <= w_rev_n;
            r_hist      <= w_hist_n;
            r_miss      <= w_miss_n;
            r_top       <= w_top_n;
            r_bottom    <= w_bottom_n;
            r_game_over <= (w_state_n == S_WIN) || (w_state_n == S_LOSE);
            r_win       <= (w_state_n == S_WIN);
        end
    end

    assign top         = r_top;
    assign bottom      = r_bottom;
    assign num_mistake = r_miss;
    assign game_over   = r_game_over;
    assign win         = r_win;

endmodule

`default_nettype wire
